rm_arbiter: RTL and testbench

RM_ARBITER -- requirements
Module: rm_arbiter

---
 rtl/rm_arb_pkg.sv | 21 ++
 rtl/rm_arb_starve_ctr.sv | 24 ++
 rtl/rm_arbiter.sv | 153 +++++++++++++++
 tb/tb_rm_arbiter.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rm_arb_pkg.sv
// Shared types and limits for the two-port Avalon-MM read arbiter.
package rm_arb_pkg;

  localparam int BURST_MAX    = 8;
  localparam int STARVE_LIMIT = 16;
  localparam int STARVE_W     = 5;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_ISSUE = 2'd1,
    ARB_DATA  = 2'd2
  } arb_state_t;

  // A zero-beat request still costs one memory read; anything longer is capped.
  function automatic logic [3:0] clamp_burst(input logic [3:0] beats, input int max_beats);
    if (beats == 4'd0) return 4'd1;
    if (int'(beats) > max_beats) return 4'(max_beats);
    return beats;
  endfunction

endpackage

// File: rtl/rm_arb_starve_ctr.sv
// Saturating wait counter for one requester; it only counts while the port
// is asking and someone else holds the memory.
module rm_arb_starve_ctr
  import rm_arb_pkg::*;
(
  input  logic                iClk,
  input  logic                iRstn,
  input  logic                req,
  input  logic                is_owner,
  input  logic                gnt,
  output logic [STARVE_W-1:0] count
);

  always_ff @(posedge iClk or negedge iRstn) begin
    if (!iRstn) begin
      count <= '0;
    end else if (!req || gnt) begin
      count <= '0;
    end else if (!is_owner && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/rm_arbiter.sv
// Two-port read arbiter (vertex / texture readers) in front of one Avalon-MM
// read master; one burst outstanding at a time.
module rm_arbiter
  import rm_arb_pkg::*;
#(
  parameter int BURST_MAX    = rm_arb_pkg::BURST_MAX,
  parameter int STARVE_LIMIT = rm_arb_pkg::STARVE_LIMIT
) (
  input  logic        iClk,
  input  logic        iRstn,
  input  logic        iReq0,
  input  logic        iReq1,
  input  logic [31:0] iAddr0,
  input  logic [31:0] iAddr1,
  input  logic [3:0]  iBurst0,
  input  logic [3:0]  iBurst1,
  input  logic        iUrgent1,
  output logic        oGnt0,
  output logic        oGnt1,
  output logic        oRdValid0,
  output logic        oRdValid1,
  output logic [31:0] oRdData0,
  output logic [31:0] oRdData1,
  output logic        oDone0,
  output logic        oDone1,
  output logic        oErr,
  output logic        oRM_read,
  output logic [31:0] oRM_readaddress,
  output logic [3:0]  oRM_burstcount,
  input  logic        iRM_waitrequest,
  input  logic        iRM_readdatavalid,
  input  logic [31:0] iRM_readdata
);

  arb_state_t    state, state_nxt;
  logic          owner, owner_nxt;
  logic          last_owner, last_owner_nxt;
  logic [31:0]   addr_q, addr_nxt;
  logic [3:0]    burst_q, burst_nxt;
  logic [3:0]    beats_q, beats_nxt;
  logic          err_q, err_nxt;
  logic          winner;
  logic          busy, in_data, gnt, last_beat;
  logic          starved0, starved1;
  logic [STARVE_W-1:0] starve0, starve1;

  assign busy      = (state != ARB_IDLE);
  assign in_data   = (state == ARB_DATA);
  assign gnt       = (state == ARB_ISSUE) && !iRM_waitrequest;
  assign last_beat = in_data && iRM_readdatavalid && (beats_q == 4'd1);
  assign starved0  = iReq0 && (32'(starve0) >= STARVE_LIMIT);
  assign starved1  = iReq1 && (32'(starve1) >= STARVE_LIMIT);

  rm_arb_starve_ctr u_starve0 (
    .iClk     (iClk),
    .iRstn    (iRstn),
    .req      (iReq0),
    .is_owner (busy && !owner),
    .gnt      (oGnt0),
    .count    (starve0)
  );

  rm_arb_starve_ctr u_starve1 (
    .iClk     (iClk),
    .iRstn    (iRstn),
    .req      (iReq1),
    .is_owner (busy && owner),
    .gnt      (oGnt1),
    .count    (starve1)
  );

  // Starvation beats the urgent hint, which beats round-robin on a tie.
  always_comb begin
    winner = 1'b0;
    if (starved0)                 winner = 1'b0;
    else if (starved1)            winner = 1'b1;
    else if (iReq1 && iUrgent1)   winner = 1'b1;
    else if (iReq0 && iReq1)      winner = ~last_owner;
    else                          winner = !iReq0;
  end

  always_ff @(posedge iClk or negedge iRstn) begin
    if (!iRstn) begin
      state      <= ARB_IDLE;
      owner      <= 1'b0;
      last_owner <= 1'b1;
      addr_q     <= '0;
      burst_q    <= '0;
      beats_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      state      <= state_nxt;
      owner      <= owner_nxt;
      last_owner <= last_owner_nxt;
      addr_q     <= addr_nxt;
      burst_q    <= burst_nxt;
      beats_q    <= beats_nxt;
      err_q      <= err_nxt;
    end
  end

  // Any beat arriving outside the data phase has no owner and is an error.
  always_comb begin
    state_nxt      = state;
    owner_nxt      = owner;
    last_owner_nxt = last_owner;
    addr_nxt       = addr_q;
    burst_nxt      = burst_q;
    beats_nxt      = beats_q;
    err_nxt        = err_q | (iRM_readdatavalid && !in_data);
    case (state)
      ARB_IDLE: begin
        if (iReq0 || iReq1) begin
          owner_nxt = winner;
          addr_nxt  = winner ? iAddr1 : iAddr0;
          burst_nxt = clamp_burst(winner ? iBurst1 : iBurst0, BURST_MAX);
          state_nxt = ARB_ISSUE;
        end
      end
      ARB_ISSUE: begin
        if (!iRM_waitrequest) begin
          beats_nxt = burst_q;
          state_nxt = ARB_DATA;
        end
      end
      ARB_DATA: begin
        if (iRM_readdatavalid) begin
          beats_nxt = beats_q - 4'd1;
          if (beats_q == 4'd1) begin
            last_owner_nxt = owner;
            state_nxt      = ARB_IDLE;
          end
        end
      end
      default: state_nxt = ARB_IDLE;
    endcase
  end

  assign oRM_read        = (state == ARB_ISSUE);
  assign oRM_readaddress = oRM_read ? addr_q : '0;
  assign oRM_burstcount  = oRM_read ? burst_q : '0;

  assign oGnt0     = gnt && !owner;
  assign oGnt1     = gnt && owner;
  assign oRdValid0 = in_data && !owner && iRM_readdatavalid;
  assign oRdValid1 = in_data && owner && iRM_readdatavalid;
  assign oRdData0  = (in_data && !owner) ? iRM_readdata : '0;
  assign oRdData1  = (in_data && owner) ? iRM_readdata : '0;
  assign oDone0    = last_beat && !owner;
  assign oDone1    = last_beat && owner;
  assign oErr      = err_q;

endmodule

// File: tb/tb_rm_arbiter.sv
// Directed bench for rm_arbiter: a transaction-level model is checked against
// every output each cycle, plus literal expectations for key scenarios.
module tb_rm_arbiter;

  localparam int BURST_MAX    = 8;
  localparam int STARVE_LIMIT = 16;

  logic        iClk, iRstn;
  logic        iReq0, iReq1, iUrgent1;
  logic [31:0] iAddr0, iAddr1;
  logic [3:0]  iBurst0, iBurst1;
  logic        oGnt0, oGnt1, oRdValid0, oRdValid1, oDone0, oDone1, oErr;
  logic [31:0] oRdData0, oRdData1;
  logic        oRM_read;
  logic [31:0] oRM_readaddress;
  logic [3:0]  oRM_burstcount;
  logic        iRM_waitrequest, iRM_readdatavalid;
  logic [31:0] iRM_readdata;

  rm_arbiter #(.BURST_MAX(BURST_MAX), .STARVE_LIMIT(STARVE_LIMIT)) dut (
    .iClk(iClk), .iRstn(iRstn),
    .iReq0(iReq0), .iReq1(iReq1), .iAddr0(iAddr0), .iAddr1(iAddr1),
    .iBurst0(iBurst0), .iBurst1(iBurst1), .iUrgent1(iUrgent1),
    .oGnt0(oGnt0), .oGnt1(oGnt1), .oRdValid0(oRdValid0), .oRdValid1(oRdValid1),
    .oRdData0(oRdData0), .oRdData1(oRdData1), .oDone0(oDone0), .oDone1(oDone1),
    .oErr(oErr), .oRM_read(oRM_read), .oRM_readaddress(oRM_readaddress),
    .oRM_burstcount(oRM_burstcount), .iRM_waitrequest(iRM_waitrequest),
    .iRM_readdatavalid(iRM_readdatavalid), .iRM_readdata(iRM_readdata)
  );

  initial begin
    iClk = 1'b0;
    forever #5 iClk = ~iClk;
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Memory slave: optional waitrequest hold, beats return back-to-back the
  // cycle after acceptance with data = address + beat index.
  int  wait_hold = 0;
  int  wait_seen = 0;
  bit  stray_req = 0;
  int  s_left = 0;
  int  s_idx = 0;
  logic [31:0] s_addr;
  bit  s_acc, s_stall;

  initial begin
    iRM_waitrequest   = 1'b0;
    iRM_readdatavalid = 1'b0;
    iRM_readdata      = '0;
    s_addr            = '0;
    forever begin
      @(negedge iClk);
      s_acc   = iRstn && oRM_read && !iRM_waitrequest;
      s_stall = iRstn && oRM_read && iRM_waitrequest;
      if (s_acc) begin
        s_addr = oRM_readaddress;
        s_left = int'(oRM_burstcount);
        s_idx  = 0;
      end
      @(posedge iClk);
      #1;
      if (s_stall) wait_seen++;
      if (s_acc) wait_seen = 0;
      iRM_waitrequest = (wait_seen < wait_hold);
      if (s_left > 0) begin
        iRM_readdatavalid = 1'b1;
        iRM_readdata      = s_addr + 32'(s_idx);
        s_idx++;
        s_left--;
      end else if (stray_req) begin
        iRM_readdatavalid = 1'b1;
        iRM_readdata      = 32'hDEAD_BEEF;
        stray_req         = 0;
      end else begin
        iRM_readdatavalid = 1'b0;
        iRM_readdata      = '0;
      end
    end
  end

  // Transaction-level model: at most one read in flight, described by who
  // owns it, whether memory has accepted it and how many beats remain.
  typedef struct {
    int          port;
    logic [31:0] addr;
    int          burst;
    int          cyc;
  } gnt_rec_t;

  gnt_rec_t glog[$];
  int cyc = 0;
  int gnt_total = 0, done0_total = 0, beats0_total = 0;
  int last_done0_cyc = 0, rd_run = 0, last_rd_run = 0;

  bit          t_active = 0, t_acc = 0;
  int          t_owner = 0, t_beats = 0, t_left = 0;
  logic [31:0] t_addr = '0;
  int          waited[2] = '{0, 0};
  int          m_last = 1;
  bit          m_err = 0;

  function automatic int effBurst(input logic [3:0] b);
    if (b == 4'd0) return 1;
    if (int'(b) > BURST_MAX) return BURST_MAX;
    return int'(b);
  endfunction

  function automatic int pickWinner(input bit r0, input bit r1, input bit urg,
                                    input int w0, input int w1, input int last);
    if (r0 && w0 >= STARVE_LIMIT) return 0;
    if (r1 && w1 >= STARVE_LIMIT) return 1;
    if (r1 && urg) return 1;
    if (r0 && r1) return 1 - last;
    return r0 ? 0 : 1;
  endfunction

  logic        e_read, e_g0, e_g1, e_v0, e_v1, e_d0n, e_d1n;
  logic [31:0] e_addr, e_bc, e_dat0, e_dat1;
  bit          in_d, own0, own1, r0, r1;
  int          w;

  always @(negedge iClk) begin
    cyc++;
    if (!iRstn) begin
      t_active = 0; t_acc = 0; t_left = 0;
      waited[0] = 0; waited[1] = 0; m_last = 1; m_err = 0;
    end
    in_d   = t_active && t_acc;
    e_read = t_active && !t_acc;
    e_addr = e_read ? t_addr : 32'h0;
    e_bc   = e_read ? 32'(t_beats) : 32'h0;
    e_g0   = e_read && !iRM_waitrequest && (t_owner == 0);
    e_g1   = e_read && !iRM_waitrequest && (t_owner == 1);
    e_v0   = in_d && (t_owner == 0) && iRM_readdatavalid;
    e_v1   = in_d && (t_owner == 1) && iRM_readdatavalid;
    e_dat0 = (in_d && t_owner == 0) ? iRM_readdata : 32'h0;
    e_dat1 = (in_d && t_owner == 1) ? iRM_readdata : 32'h0;
    e_d0n  = e_v0 && (t_left == 1);
    e_d1n  = e_v1 && (t_left == 1);

    checkOutput("rm_read", 32'(oRM_read), 32'(e_read));
    checkOutput("rm_address", oRM_readaddress, e_addr);
    checkOutput("rm_burstcount", 32'(oRM_burstcount), e_bc);
    checkOutput("gnt0", 32'(oGnt0), 32'(e_g0));
    checkOutput("gnt1", 32'(oGnt1), 32'(e_g1));
    checkOutput("rdvalid0", 32'(oRdValid0), 32'(e_v0));
    checkOutput("rdvalid1", 32'(oRdValid1), 32'(e_v1));
    checkOutput("rddata0", oRdData0, e_dat0);
    checkOutput("rddata1", oRdData1, e_dat1);
    checkOutput("done0", 32'(oDone0), 32'(e_d0n));
    checkOutput("done1", 32'(oDone1), 32'(e_d1n));
    checkOutput("err", 32'(oErr), 32'(m_err));

    if (oGnt0 || oGnt1) begin
      glog.push_back('{port: (oGnt1 ? 1 : 0), addr: oRM_readaddress,
                       burst: int'(oRM_burstcount), cyc: cyc});
      gnt_total++;
    end
    if (oDone0) begin done0_total++; last_done0_cyc = cyc; end
    if (oRdValid0) beats0_total++;
    if (oRM_read) rd_run++;
    else if (rd_run > 0) begin last_rd_run = rd_run; rd_run = 0; end

    if (iRstn) begin
      own0 = t_active && (t_owner == 0);
      own1 = t_active && (t_owner == 1);
      r0 = iReq0; r1 = iReq1;
      m_err = m_err || (iRM_readdatavalid && !in_d);
      if (!t_active) begin
        if (r0 || r1) begin
          w        = pickWinner(r0, r1, iUrgent1, waited[0], waited[1], m_last);
          t_active = 1;
          t_acc    = 0;
          t_owner  = w;
          t_addr   = (w == 1) ? iAddr1 : iAddr0;
          t_beats  = effBurst((w == 1) ? iBurst1 : iBurst0);
        end
      end else if (!t_acc) begin
        if (!iRM_waitrequest) begin t_acc = 1; t_left = t_beats; end
      end else if (iRM_readdatavalid) begin
        t_left--;
        if (t_left == 0) begin t_active = 0; m_last = t_owner; end
      end
      if (!r0 || e_g0) waited[0] = 0;
      else if (!own0 && waited[0] < 31) waited[0]++;
      if (!r1 || e_g1) waited[1] = 0;
      else if (!own1 && waited[1] < 31) waited[1]++;
    end
  end

  task automatic applyStimulus(input bit r0, input bit r1, input bit urg,
                               input logic [31:0] a0, input logic [31:0] a1,
                               input logic [3:0] b0, input logic [3:0] b1);
    iReq0 = r0; iReq1 = r1; iUrgent1 = urg;
    iAddr0 = a0; iAddr1 = a1; iBurst0 = b0; iBurst1 = b1;
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(posedge iClk);
    #1;
  endtask

  task automatic waitGnt(input int port, input int limit, output int lat);
    bit found;
    found = 0;
    lat = limit;
    for (int i = 0; i < limit; i++) begin
      @(negedge iClk);
      if ((port == 0 && oGnt0) || (port == 1 && oGnt1)) begin
        found = 1;
        lat = i;
        break;
      end
    end
    if (!found) checkOutput("gnt_timeout", 32'(port), 32'hFFFF_FFFF);
    @(posedge iClk);
    #1;
  endtask

  task automatic pulseReset(input int n);
    iRstn = 1'b0;
    waitCycles(n);
    iRstn = 1'b1;
  endtask

  int base, lat, d0, bt, g0;

  initial begin
    iRstn = 1'b0;
    applyStimulus(0, 0, 0, 32'h0, 32'h0, 4'd0, 4'd0);
    #2;
    checkOutput("reset_read", 32'(oRM_read), 32'h0);
    checkOutput("reset_err", 32'(oErr), 32'h0);
    checkOutput("reset_gnt0", 32'(oGnt0), 32'h0);
    waitCycles(2);
    iRstn = 1'b1;
    waitCycles(1);

    $display("[TB] tie after reset goes to port 0, next tie to port 1");
    base = glog.size();
    applyStimulus(1, 1, 0, 32'h1000, 32'h2000, 4'd8, 4'd4);
    waitGnt(0, 50, lat);
    waitGnt(1, 50, lat);
    applyStimulus(0, 0, 0, 32'h0, 32'h0, 4'd0, 4'd0);
    waitCycles(12);
    checkOutput("tie1_port", 32'(glog[base].port), 32'd0);
    checkOutput("tie1_addr", glog[base].addr, 32'h1000);
    checkOutput("tie1_burst", 32'(glog[base].burst), 32'd8);
    checkOutput("tie2_port", 32'(glog[base+1].port), 32'd1);
    checkOutput("tie2_burst", 32'(glog[base+1].burst), 32'd4);

    $display("[TB] urgent port 1 waits for port 0 burst to finish");
    base = glog.size();
    d0 = done0_total;
    applyStimulus(1, 0, 0, 32'h3000, 32'h0, 4'd8, 4'd0);
    waitGnt(0, 50, lat);
    applyStimulus(0, 1, 1, 32'h0, 32'h4000, 4'd0, 4'd1);
    waitGnt(1, 50, lat);
    applyStimulus(0, 0, 0, 32'h0, 32'h0, 4'd0, 4'd0);
    checkOutput("urg_done0_count", 32'(done0_total - d0), 32'd1);
    checkOutput("urg_gnt1_after_done", 32'(glog[base+1].cyc - last_done0_cyc), 32'd2);
    checkOutput("urg_gnt1_burst", 32'(glog[base+1].burst), 32'd1);
    waitCycles(8);

    $display("[TB] waitrequest held five cycles");
    wait_hold = 5;
    waitCycles(1);
    base = glog.size();
    g0 = gnt_total;
    applyStimulus(1, 0, 0, 32'h5000, 32'h0, 4'd3, 4'd0);
    waitGnt(0, 50, lat);
    applyStimulus(0, 0, 0, 32'h0, 32'h0, 4'd0, 4'd0);
    wait_hold = 0;
    waitCycles(8);
    checkOutput("wait_read_cycles", 32'(last_rd_run), 32'd6);
    checkOutput("wait_gnt_pulses", 32'(gnt_total - g0), 32'd1);
    checkOutput("wait_addr", glog[base].addr, 32'h5000);

    $display("[TB] burst width rule");
    base = glog.size();
    bt = beats0_total;
    applyStimulus(1, 0, 0, 32'h6000, 32'h0, 4'd0, 4'd0);
    waitGnt(0, 50, lat);
    applyStimulus(0, 0, 0, 32'h0, 32'h0, 4'd0, 4'd0);
    waitCycles(5);
    checkOutput("burst0_count", 32'(glog[base].burst), 32'd1);
    checkOutput("burst0_beats", 32'(beats0_total - bt), 32'd1);
    base = glog.size();
    bt = beats0_total;
    d0 = done0_total;
    applyStimulus(1, 0, 0, 32'h6100, 32'h0, 4'd15, 4'd0);
    waitGnt(0, 50, lat);
    applyStimulus(0, 0, 0, 32'h0, 32'h0, 4'd0, 4'd0);
    waitCycles(12);
    checkOutput("burst15_count", 32'(glog[base].burst), 32'd8);
    checkOutput("burst15_beats", 32'(beats0_total - bt), 32'd8);
    checkOutput("burst15_done", 32'(done0_total - d0), 32'd1);

    $display("[TB] starvation overrides a permanently urgent port 1");
    base = glog.size();
    applyStimulus(1, 1, 1, 32'h7000, 32'h8000, 4'd2, 4'd8);
    waitGnt(0, 100, lat);
    applyStimulus(0, 0, 0, 32'h0, 32'h0, 4'd0, 4'd0);
    checkOutput("starve_latency_ok", 32'(lat <= STARVE_LIMIT + 12), 32'd1);
    checkOutput("starve_first_port", 32'(glog[base].port), 32'd1);
    checkOutput("starve_win_port", 32'(glog[base+2].port), 32'd0);
    waitCycles(15);

    $display("[TB] stray beat in idle");
    stray_req = 1;
    waitCycles(4);
    checkOutput("stray_err", 32'(oErr), 32'd1);
    waitCycles(3);
    checkOutput("stray_err_sticky", 32'(oErr), 32'd1);
    pulseReset(2);
    waitCycles(1);
    checkOutput("err_cleared", 32'(oErr), 32'd0);

    $display("[TB] reset in the middle of a burst");
    applyStimulus(1, 0, 0, 32'h9000, 32'h0, 4'd8, 4'd0);
    waitGnt(0, 50, lat);
    applyStimulus(0, 0, 0, 32'h0, 32'h0, 4'd0, 4'd0);
    waitCycles(2);
    pulseReset(1);
    waitCycles(3);
    checkOutput("midburst_err", 32'(oErr), 32'd1);
    checkOutput("midburst_read", 32'(oRM_read), 32'd0);
    waitCycles(6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
